// File: rtl/restoring_divider8_pkg.sv
// Shared definitions for the restoring divider: default width, step-counter
// width and the FSM state encoding.
package restoring_divider8_pkg;

  localparam int DIV_WIDTH = 8;
  localparam int CNT_W     = $clog2(DIV_WIDTH + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FIN  = 2'd2;

endpackage

// File: rtl/restoring_divider8_sub_cla.sv
// Combinational W-bit subtractor x + ~y + 1 with full lookahead carries.
// cout = 1 means x >= y (no borrow).
module sub_cla #(
  parameter int W = 9
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  output logic [W-1:0] diff,
  output logic         cout
);

  logic [W-1:0] g;
  logic [W-1:0] p;
  logic [W:0]   c;

  assign g = x & ~y;
  assign p = x ^ ~y;

  // Carry into bit i as a flat sum of generate terms masked by propagate
  // products, with the constant carry-in of 1 as the final term.
  function automatic logic carry_into(input logic [W-1:0] gv,
                                      input logic [W-1:0] pv,
                                      input int i);
    logic c_acc;
    logic p_acc;
    c_acc = 1'b0;
    p_acc = 1'b1;
    for (int j = i - 1; j >= 0; j--) begin
      c_acc = c_acc | (p_acc & gv[j]);
      p_acc = p_acc & pv[j];
    end
    return c_acc | p_acc;
  endfunction

  for (genvar i = 0; i <= W; i++) begin : g_carry
    assign c[i] = carry_into(g, p, i);
  end

  assign diff = p ^ c[W-1:0];
  assign cout = c[W];

endmodule

// File: rtl/restoring_divider8.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// Handshake: START is taken only in IDLE; DONE pulses once with Q/R/DZ valid, and they hold until the next accepted START.
module restoring_divider8
  import restoring_divider8_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             DZ,
  output logic [1:0]       dbg_state
);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH:0]   p;
  logic [WIDTH-1:0] b_reg;

  logic [WIDTH:0]   p_shift;
  logic [WIDTH:0]   t;
  logic             no_borrow;
  logic [WIDTH:0]   p_next;

  // Shift the dividend MSB (held in Q) into the partial remainder.
  assign p_shift = (p << 1) | (WIDTH + 1)'(Q[WIDTH-1]);

  sub_cla #(
    .W (WIDTH + 1)
  ) u_sub (
    .x    (p_shift),
    .y    ({1'b0, b_reg}),
    .diff (t),
    .cout (no_borrow)
  );

  assign p_next = no_borrow ? t : p_shift;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= ST_IDLE;
      cnt   <= '0;
      p     <= '0;
      b_reg <= '0;
      Q     <= '0;
      R     <= '0;
      DZ    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (START) begin
            if (B != '0) begin
              b_reg <= B;
              p     <= '0;
              Q     <= A;
              cnt   <= CNT_W'(WIDTH);
              DZ    <= 1'b0;
              state <= ST_RUN;
            end else begin
              Q     <= '1;
              R     <= A;
              DZ    <= 1'b1;
              state <= ST_FIN;
            end
          end
        end
        ST_RUN: begin
          p   <= p_next;
          Q   <= {Q[WIDTH-2:0], no_borrow};
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            R     <= p_next[WIDTH-1:0];
            state <= ST_FIN;
          end
        end
        ST_FIN:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign BUSY      = (state == ST_RUN);
  assign DONE      = (state == ST_FIN);
  assign dbg_state = state;

endmodule

// File: tb/tb_restoring_divider8.sv
// Directed bench for restoring_divider8: drivers push expected results into
// queues, a monitor pops and compares on every DONE.
module tb_restoring_divider8;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] q;
  logic [W-1:0] r;
  logic         dz;
  logic [1:0]   dbg_state;

  restoring_divider8 #(.WIDTH(W)) dut (
    .CLK       (clk),
    .RST       (rst),
    .START     (start),
    .A         (a),
    .B         (b),
    .BUSY      (busy),
    .DONE      (done),
    .Q         (q),
    .R         (r),
    .DZ        (dz),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  logic [2*W:0] exp_q[$];
  int           exp_edge_q[$];
  int           exp_busy_q[$];
  int           n_checks = 0;
  int           n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [W-1:0] av;
    logic [W-1:0] bv;
    logic [W-1:0] eq;
    logic [W-1:0] er;
    logic         edz;
  } vec_t;

  // ---------------- monitor ----------------
  logic [2*W:0] last_res = '0;
  logic         prev_done = 1'b0;
  logic         hold_chk = 1'b0;
  int           busy_run = 0;

  initial begin
    logic [2*W:0] e;
    int           e_edge;
    int           e_busy;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        busy_run  = 0;
        prev_done = 1'b0;
        hold_chk  = 1'b0;
      end else begin
        if (hold_chk) begin
          check("hold_q",  {24'd0, q},  {24'd0, last_res[2*W:W+1]});
          check("hold_r",  {24'd0, r},  {24'd0, last_res[W:1]});
          check("hold_dz", {31'd0, dz}, {31'd0, last_res[0]});
          hold_chk = 1'b0;
        end
        if (busy) busy_run++;
        if (done) begin
          check("done_pulse", {31'd0, prev_done}, 32'd0);
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_done: got DONE, expected none (t=%0t)", $time);
          end else begin
            e      = exp_q.pop_front();
            e_edge = exp_edge_q.pop_front();
            e_busy = exp_busy_q.pop_front();
            check("q",          {24'd0, q},  {24'd0, e[2*W:W+1]});
            check("r",          {24'd0, r},  {24'd0, e[W:1]});
            check("dz",         {31'd0, dz}, {31'd0, e[0]});
            check("done_cycle", cycle,       e_edge);
            check("busy_len",   busy_run,    e_busy);
            last_res = e;
            hold_chk = 1'b1;
          end
          busy_run = 0;
        end
        prev_done = done;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_exp(input vec_t v, input int k);
    exp_q.push_back({v.eq, v.er, v.edz});
    exp_edge_q.push_back((v.bv == '0) ? k : k + W);
    exp_busy_q.push_back((v.bv == '0) ? 0 : W);
  endtask

  // Waits for IDLE at a falling edge; returns the index of the next rising edge.
  task automatic wait_idle(output int k, output bit ok);
    int guard = 0;
    @(negedge clk);
    while (dbg_state !== 2'd0 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    ok = (guard < 100);
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL idle_timeout: got state %0d, expected IDLE within 100 cycles", dbg_state);
    end
    k = cycle + 1;
  endtask

  task automatic start_op(input vec_t v, input bit expect_done);
    int k;
    bit ok;
    wait_idle(k, ok);
    if (ok) begin
      a     = v.av;
      b     = v.bv;
      start = 1'b1;
      if (expect_done) push_exp(v, k);
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  task automatic drain;
    int guard = 0;
    while (exp_q.size() != 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("drain", exp_q.size(), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  vec_t basic[8] = '{
    '{8'd100, 8'd7,   8'd14,  8'd2,   1'b0},
    '{8'd255, 8'd1,   8'd255, 8'd0,   1'b0},
    '{8'd5,   8'd9,   8'd0,   8'd5,   1'b0},
    '{8'd255, 8'd255, 8'd1,   8'd0,   1'b0},
    '{8'd200, 8'd0,   8'd255, 8'd200, 1'b1},
    '{8'd9,   8'd3,   8'd3,   8'd0,   1'b0},
    '{8'd50,  8'd5,   8'd10,  8'd0,   1'b0},
    '{8'd17,  8'd4,   8'd4,   8'd1,   1'b0}
  };

  vec_t sweep[14] = '{
    '{8'd0,   8'd1,   8'd0,   8'd0,   1'b0},
    '{8'd1,   8'd2,   8'd0,   8'd1,   1'b0},
    '{8'd128, 8'd3,   8'd42,  8'd2,   1'b0},
    '{8'd254, 8'd16,  8'd15,  8'd14,  1'b0},
    '{8'd77,  8'd0,   8'd255, 8'd77,  1'b1},
    '{8'd13,  8'd13,  8'd1,   8'd0,   1'b0},
    '{8'd250, 8'd128, 8'd1,   8'd122, 1'b0},
    '{8'd99,  8'd10,  8'd9,   8'd9,   1'b0},
    '{8'd0,   8'd0,   8'd255, 8'd0,   1'b1},
    '{8'd143, 8'd11,  8'd13,  8'd0,   1'b0},
    '{8'd255, 8'd2,   8'd127, 8'd1,   1'b0},
    '{8'd64,  8'd8,   8'd8,   8'd0,   1'b0},
    '{8'd201, 8'd15,  8'd13,  8'd6,   1'b0},
    '{8'd7,   8'd200, 8'd0,   8'd7,   1'b0}
  };

  initial begin
    int  k;
    int  prev_k;
    bit  ok;
    logic [W-1:0] prev_b;

    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;

    // reset state
    #12;
    check("rst_busy",  {31'd0, busy}, 32'd0);
    check("rst_done",  {31'd0, done}, 32'd0);
    check("rst_q",     {24'd0, q},    32'd0);
    check("rst_r",     {24'd0, r},    32'd0);
    check("rst_dz",    {31'd0, dz},   32'd0);
    check("rst_state", {30'd0, dbg_state}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // basic divides, zero divisor, DZ cleared by next normal divide
    for (int i = 0; i < 6; i++) start_op(basic[i], 1'b1);
    drain();

    // START pulsed mid-run with new operands must be ignored
    start_op(basic[6], 1'b1);
    repeat (2) @(negedge clk);
    start = 1'b1;
    a     = 8'd1;
    b     = 8'd1;
    check("busy_mid", {31'd0, busy}, 32'd1);
    @(negedge clk);
    start = 1'b0;
    a     = 8'd77;
    b     = 8'd3;
    drain();

    // async reset in the fourth RUN cycle aborts with no DONE
    start_op(basic[0], 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_busy",  {31'd0, busy}, 32'd0);
    check("abort_done",  {31'd0, done}, 32'd0);
    check("abort_q",     {24'd0, q},    32'd0);
    check("abort_r",     {24'd0, r},    32'd0);
    check("abort_dz",    {31'd0, dz},   32'd0);
    check("abort_state", {30'd0, dbg_state}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    start_op(basic[7], 1'b1);
    drain();

    // START held high: back-to-back operations at full throughput
    prev_k = 0;
    prev_b = '0;
    for (int i = 0; i < 14; i++) begin
      wait_idle(k, ok);
      if (ok) begin
        a     = sweep[i].av;
        b     = sweep[i].bv;
        start = 1'b1;
        if (i > 0) check("spacing", k - prev_k, (prev_b == '0) ? 2 : W + 2);
        push_exp(sweep[i], k);
        prev_k = k;
        prev_b = sweep[i].bv;
      end
    end
    @(negedge clk);
    start = 1'b0;
    drain();

    check("queue_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
